ring_phase_monitor: RTL and testbench
=====================================

// Module: ring_phase_monitor
// PURPOSE
//   Sits directly downstream of the 8-bit one-hot ring counter and consumes its output vector.
//   Checks every accepted sample: exactly one bit set, and a rotate-left-by-one step from the previous sample.
//   Encodes the hot bit to a binary phase index, pulses once per revolution, and locks after clean rotations.
//   Raises a sticky fault for the control plane.
// PARAMETERS
//   WIDTH     8   ring width in bits; WIDTH >= 2
//   LOCK_CNT  4   consecutive correct rotations required to reach LOCKED; >= 1
//   CNT_W     16  revolution counter width (used only with RING_MON_CNT_EN)
// PORTS
//   clk        in   1                    single clock; all logic on posedge clk
//   reset      in   1                    synchronous, active-high reset
//   ring_in    in   WIDTH                ring counter state vector
//   ring_vld   in   1                    ring_in valid this cycle; sample ignored when low
//   fault_clr  in   1                    clears FAULT, returns to IDLE
//   phase_idx  out  $clog2(WIDTH)        binary index of the hot bit of the last good sample
//   phase_vld  out  1                    phase_idx updated this cycle (1-cycle pulse)
//   wrap_pulse out  1                    1-cycle pulse on good step from index WIDTH-1 to index 0
//   locked     out  1                    high while in LOCKED
//   fault      out  1                    high while in FAULT (sticky until fault_clr or reset)
//   fault_code out  2                    00 none, 01 not one-hot, 10 bad rotation; held in FAULT
//   rev_count  out  CNT_W                revolutions completed while LOCKED (RING_MON_CNT_EN only)
// BEHAVIOUR
//   - Reset (sync, any state, mid-operation included): state=IDLE; all outputs 0; expected/prev regs 0.
//   - All outputs registered; sample presented in cycle N appears in outputs in cycle N+1.
//   - ring_vld=0: no state change; phase_vld, wrap_pulse = 0; other outputs hold.
//   - Per valid sample:
//     - oh_ok = exactly one bit set.
//     - rot_ok = (ring_in == rotl(prev,1)).
//     - good = oh_ok && rot_ok; not one-hot takes priority over bad rotation when coding.
//   - FSM: IDLE, SYNC, LOCKED, FAULT
//     - IDLE  : valid && oh_ok -> SYNC, prev=ring_in, ok_cnt=0; valid && !oh_ok -> stay IDLE (no fault).
//     - SYNC  : valid && good -> ok_cnt++, prev=ring_in; -> LOCKED when ok_cnt reaches LOCK_CNT.
//               valid && !good -> IDLE, ok_cnt=0 (not sticky; resync).
//     - LOCKED: valid && good -> prev=ring_in; valid && !good -> FAULT, latch fault_code, prev held.
//     - FAULT : ignores ring_in; fault_clr -> IDLE.
//   - fault_clr in a non-FAULT state has no effect.
//   - fault_clr with a bad sample in the same cycle: clear wins -> IDLE; that sample is discarded.
//   - phase_idx/phase_vld update on every oh_ok sample accepted in IDLE, SYNC or LOCKED, never in FAULT.
//   - wrap_pulse fires in SYNC and LOCKED only, on a good step with prev[WIDTH-1]=1.
//   - ok_cnt saturates; width $clog2(LOCK_CNT+1).
// CONFIGURATION
//   Macro: RING_MON_CNT_EN
//   - Defined: rev_count port present.
//     - Increments on each wrap_pulse while LOCKED; wraps modulo 2^CNT_W.
//     - Cleared by reset and by entry to IDLE.
//   - Undefined: rev_count port and counter absent; CNT_W unused; all other behaviour identical.
// STRUCTURE
//   - Package ring_mon_pkg:
//     - state enum {IDLE, SYNC, LOCKED, FAULT}.
//     - fault code constants FC_NONE=2'b00, FC_NOHOT=2'b01, FC_ROT=2'b10.
//     - function rotl1(vec) (rotate left by one).
//   - Sub-module onehot_enc: combinational; WIDTH -> idx, oh_ok (zero and multi-hot both give oh_ok=0).
//   - Top holds the FSM, prev reg, ok_cnt, output regs and the optional counter.
// TESTING
//   1. Reset, then 01,02,04,08,10,20,40,80,01 (WIDTH=8, LOCK_CNT=4)
//      -> phase_idx 0..7,0; locked=1 after 5th sample; wrap_pulse once on 80->01.
//   2. While LOCKED, inject 0x06 -> next cycle fault=1, fault_code=01, locked=0; later valid samples ignored.
//   3. While LOCKED, inject 0x08 after 0x02 -> fault=1, fault_code=10.
//      Then fault_clr=1 -> IDLE; fault=0, fault_code=00.
//   4. In SYNC, inject 0x00 -> return to IDLE, fault stays 0.
//      Three clean rotations after that -> no lock until the LOCK_CNT-th good step.
//   5. Same-cycle fault_clr and bad sample in FAULT -> IDLE, no re-fault.
//      Assert reset mid-LOCKED -> all outputs 0 next cycle.
//   6. RING_MON_CNT_EN: run 3 revolutions locked -> rev_count=3.
//      Stall with ring_vld=0 for 5 cycles -> all outputs hold, no pulses.

Source files
------------

// File: rtl/ring_mon_pkg.sv
// ring_mon_pkg: shared state encoding, fault codes and rotate helper for the ring phase monitor
package ring_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_NOHOT = 2'b01;
  localparam logic [1:0] FC_ROT   = 2'b10;

  // Rotate the low w bits of v left by one; bits above w come back as zero.
  function automatic logic [63:0] rotl1(input logic [63:0] v, input int w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((v << 1) | (v >> (w - 1))) & m;
  endfunction

endpackage

// File: rtl/ring_phase_monitor_if.sv
// ring_phase_monitor_if: sample input and status bundle; rev_count exists only with RING_MON_CNT_EN
interface ring_phase_monitor_if #(
  parameter int WIDTH = 8
`ifdef RING_MON_CNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic [WIDTH-1:0]         ring_in;
  logic                     ring_vld;
  logic                     fault_clr;
  logic [$clog2(WIDTH)-1:0] phase_idx;
  logic                     phase_vld;
  logic                     wrap_pulse;
  logic                     locked;
  logic                     fault;
  logic [1:0]               fault_code;
`ifdef RING_MON_CNT_EN
  logic [CNT_W-1:0]         rev_count;
`endif

  modport master (
    output ring_in, ring_vld, fault_clr,
    input  phase_idx, phase_vld, wrap_pulse, locked, fault, fault_code
`ifdef RING_MON_CNT_EN
    , input rev_count
`endif
  );

  modport slave (
    input  ring_in, ring_vld, fault_clr,
    output phase_idx, phase_vld, wrap_pulse, locked, fault, fault_code
`ifdef RING_MON_CNT_EN
    , output rev_count
`endif
  );
endinterface

// File: rtl/ring_phase_monitor_onehot_enc.sv
// onehot_enc: binary index of the hot bit plus an exactly-one-bit-set flag (zero and multi-hot fail)
module onehot_enc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         vec_i,
  output logic [$clog2(WIDTH)-1:0] idx_o,
  output logic                     oh_ok_o
);
  localparam int IW = $clog2(WIDTH);

  // Highest set bit wins; only meaningful when oh_ok_o is high
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) if (vec_i[i]) idx_o = IW'(i);
  end

  assign oh_ok_o = (vec_i != '0) && ((vec_i & (vec_i - 1'b1)) == '0);
endmodule

// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: checks one-hot ring samples for correct rotation, tracks lock/fault; RING_MON_CNT_EN adds rev_count
module ring_phase_monitor
  import ring_mon_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4
`ifdef RING_MON_CNT_EN
  , parameter int CNT_W  = 16
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  ring_phase_monitor_if.slave  bus
);
  localparam int IW  = $clog2(WIDTH);
  localparam int OKW = $clog2(LOCK_CNT + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [OKW-1:0]   ok_q, ok_d;
  logic [IW-1:0]    pidx_q, pidx_d;
  logic             pvld_q, pvld_d;
  logic             wrap_q, wrap_d;
  logic [1:0]       fc_q, fc_d;
  logic [IW-1:0]    idx;
  logic             oh_ok, rot_ok, good, vld;

  onehot_enc #(.WIDTH(WIDTH)) u_enc (
    .vec_i   (bus.ring_in),
    .idx_o   (idx),
    .oh_ok_o (oh_ok)
  );

  assign vld    = bus.ring_vld;
  assign rot_ok = 64'(bus.ring_in) == rotl1(64'(prev_q), WIDTH);
  assign good   = oh_ok && rot_ok;

  // Next state, expected-sample tracking and registered output values
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    ok_d    = ok_q;
    fc_d    = fc_q;
    pvld_d  = vld && oh_ok && state_q != FAULT;
    pidx_d  = pvld_d ? idx : pidx_q;
    wrap_d  = vld && good && prev_q[WIDTH-1] && (state_q == SYNC || state_q == LOCKED);
    unique case (state_q)
      IDLE: if (vld && oh_ok) begin
        state_d = SYNC;
        prev_d  = bus.ring_in;
        ok_d    = '0;
      end
      SYNC: if (vld && good) begin
        prev_d  = bus.ring_in;
        ok_d    = (ok_q == OKW'(LOCK_CNT)) ? ok_q : ok_q + 1'b1;
        state_d = (ok_q == OKW'(LOCK_CNT - 1)) ? LOCKED : SYNC;
      end else if (vld) begin
        state_d = IDLE;
        ok_d    = '0;
      end
      LOCKED: if (vld && good) prev_d = bus.ring_in;
      else if (vld) begin
        state_d = FAULT;
        fc_d    = oh_ok ? FC_ROT : FC_NOHOT;
      end
      FAULT: if (bus.fault_clr) begin
        state_d = IDLE;
        fc_d    = FC_NONE;
        ok_d    = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= '0;
      ok_q    <= '0;
      pidx_q  <= '0;
      pvld_q  <= 1'b0;
      wrap_q  <= 1'b0;
      fc_q    <= FC_NONE;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      ok_q    <= ok_d;
      pidx_q  <= pidx_d;
      pvld_q  <= pvld_d;
      wrap_q  <= wrap_d;
      fc_q    <= fc_d;
    end
  end

  assign bus.phase_idx  = pidx_q;
  assign bus.phase_vld  = pvld_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.locked     = state_q == LOCKED;
  assign bus.fault      = state_q == FAULT;
  assign bus.fault_code = fc_q;

`ifdef RING_MON_CNT_EN
  logic [CNT_W-1:0] rev_q, rev_d;

  // Count revolutions seen while locked; any return to IDLE starts over
  always_comb begin
    rev_d = (state_d == IDLE && state_q != IDLE) ? '0 :
            (state_q == LOCKED && wrap_d)        ? rev_q + 1'b1 : rev_q;
  end

  // Revolution counter register
  always_ff @(posedge clk) begin
    if (reset) rev_q <= '0;
    else       rev_q <= rev_d;
  end

  assign bus.rev_count = rev_q;
`endif
endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb_ring_phase_monitor: directed checks of lock, wrap, fault coding, clear and reset behaviour
module tb_ring_phase_monitor;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

`ifdef RING_MON_CNT_EN
  ring_phase_monitor_if #(.WIDTH(8), .CNT_W(16)) bus ();
  ring_phase_monitor #(.WIDTH(8), .LOCK_CNT(4), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
`else
  ring_phase_monitor_if #(.WIDTH(8)) bus ();
  ring_phase_monitor #(.WIDTH(8), .LOCK_CNT(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
`endif

  task automatic step(input logic [7:0] v, input logic vld, input logic clr);
    bus.ring_in   = v;
    bus.ring_vld  = vld;
    bus.fault_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int s, input int n);
    for (int k = 0; k < n; k++) step(8'(1 << ((s + k) % 8)), 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(8'h01, 1'b1, 1'b0);
    reset = 1'b0;
    n_vec++;
    if ({bus.phase_idx, bus.phase_vld, bus.wrap_pulse, bus.locked, bus.fault, bus.fault_code} !== 9'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 000", {bus.phase_idx, bus.phase_vld, bus.wrap_pulse, bus.locked, bus.fault, bus.fault_code});
    end
  endtask

  task automatic test_rotation();
    for (int i = 0; i < 9; i++) begin
      step(8'(1 << (i % 8)), 1'b1, 1'b0);
      n_vec += 4;
      if (bus.phase_idx !== 3'(i % 8)) begin n_bad++; $display("FAIL rot_idx[%0d]: got %0d want %0d", i, bus.phase_idx, i % 8); end
      if (bus.phase_vld !== 1'b1) begin n_bad++; $display("FAIL rot_pvld[%0d]: got %b want 1", i, bus.phase_vld); end
      if (bus.locked !== (i >= 4)) begin n_bad++; $display("FAIL rot_locked[%0d]: got %b want %b", i, bus.locked, i >= 4); end
      if (bus.wrap_pulse !== (i == 8)) begin n_bad++; $display("FAIL rot_wrap[%0d]: got %b want %b", i, bus.wrap_pulse, i == 8); end
    end
  endtask

  task automatic test_nohot();
    step(8'h06, 1'b1, 1'b0);
    n_vec += 4;
    if (bus.fault !== 1'b1) begin n_bad++; $display("FAIL nohot_fault: got %b want 1", bus.fault); end
    if (bus.fault_code !== 2'b01) begin n_bad++; $display("FAIL nohot_code: got %b want 01", bus.fault_code); end
    if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL nohot_locked: got %b want 0", bus.locked); end
    if (bus.phase_vld !== 1'b0) begin n_bad++; $display("FAIL nohot_pvld: got %b want 0", bus.phase_vld); end
    step(8'h02, 1'b1, 1'b0);
    n_vec += 3;
    if (bus.fault !== 1'b1) begin n_bad++; $display("FAIL nohot_sticky: got %b want 1", bus.fault); end
    if (bus.phase_vld !== 1'b0) begin n_bad++; $display("FAIL nohot_ignored_pvld: got %b want 0", bus.phase_vld); end
    if (bus.phase_idx !== 3'd0) begin n_bad++; $display("FAIL nohot_idx_hold: got %0d want 0", bus.phase_idx); end
    step(8'h00, 1'b0, 1'b1);
    n_vec++;
    if ({bus.fault, bus.fault_code} !== 3'b000) begin n_bad++; $display("FAIL nohot_clear: got %b want 000", {bus.fault, bus.fault_code}); end
  endtask

  task automatic test_badrot();
    feed(5, 3);
    step(8'h01, 1'b1, 1'b0);
    n_vec += 2;
    if (bus.wrap_pulse !== 1'b1) begin n_bad++; $display("FAIL sync_wrap: got %b want 1", bus.wrap_pulse); end
    if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL sync_not_locked: got %b want 0", bus.locked); end
    step(8'h02, 1'b1, 1'b0);
    n_vec++;
    if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL badrot_lock: got %b want 1", bus.locked); end
    step(8'h08, 1'b1, 1'b0);
    n_vec += 3;
    if (bus.fault !== 1'b1) begin n_bad++; $display("FAIL badrot_fault: got %b want 1", bus.fault); end
    if (bus.fault_code !== 2'b10) begin n_bad++; $display("FAIL badrot_code: got %b want 10", bus.fault_code); end
    if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL badrot_locked: got %b want 0", bus.locked); end
    step(8'h00, 1'b0, 1'b1);
    n_vec += 2;
    if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL badrot_clr_fault: got %b want 0", bus.fault); end
    if (bus.fault_code !== 2'b00) begin n_bad++; $display("FAIL badrot_clr_code: got %b want 00", bus.fault_code); end
  endtask

  task automatic test_sync_drop();
    feed(0, 2);
    step(8'h00, 1'b1, 1'b0);
    n_vec += 3;
    if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL drop_fault: got %b want 0", bus.fault); end
    if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL drop_locked: got %b want 0", bus.locked); end
    if (bus.phase_vld !== 1'b0) begin n_bad++; $display("FAIL drop_pvld: got %b want 0", bus.phase_vld); end
    feed(2, 4);
    n_vec++;
    if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL drop_early_lock: got %b want 0", bus.locked); end
    step(8'h40, 1'b1, 1'b0);
    n_vec++;
    if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL drop_relock: got %b want 1", bus.locked); end
    step(8'h80, 1'b1, 1'b1);
    n_vec++;
    if ({bus.locked, bus.fault} !== 2'b10) begin n_bad++; $display("FAIL clr_outside_fault: got %b want 10", {bus.locked, bus.fault}); end
  endtask

  task automatic test_clr_same_cycle();
    step(8'h03, 1'b1, 1'b0);
    n_vec++;
    if ({bus.fault, bus.fault_code} !== 3'b101) begin n_bad++; $display("FAIL same_pre_fault: got %b want 101", {bus.fault, bus.fault_code}); end
    step(8'h03, 1'b1, 1'b1);
    n_vec++;
    if ({bus.fault, bus.fault_code, bus.locked, bus.phase_vld} !== 5'b00000) begin
      n_bad++; $display("FAIL same_clr_wins: got %b want 00000", {bus.fault, bus.fault_code, bus.locked, bus.phase_vld});
    end
    step(8'h03, 1'b1, 1'b0);
    n_vec++;
    if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL idle_no_fault: got %b want 0", bus.fault); end
    feed(0, 5);
    n_vec++;
    if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL prereset_lock: got %b want 1", bus.locked); end
    reset = 1'b1;
    step(8'h20, 1'b1, 1'b0);
    reset = 1'b0;
    n_vec++;
    if ({bus.phase_idx, bus.phase_vld, bus.wrap_pulse, bus.locked, bus.fault, bus.fault_code} !== 9'h0) begin
      n_bad++; $display("FAIL midlock_reset: got %h want 000", {bus.phase_idx, bus.phase_vld, bus.wrap_pulse, bus.locked, bus.fault, bus.fault_code});
    end
  endtask

  task automatic test_stall();
    feed(0, 8);
    for (int r = 1; r <= 3; r++) begin
      step(8'h01, 1'b1, 1'b0);
      n_vec++;
      if (bus.wrap_pulse !== 1'b1) begin n_bad++; $display("FAIL rev_wrap[%0d]: got %b want 1", r, bus.wrap_pulse); end
`ifdef RING_MON_CNT_EN
      n_vec++;
      if (bus.rev_count !== 16'(r)) begin n_bad++; $display("FAIL rev_count[%0d]: got %0d want %0d", r, bus.rev_count, r); end
`endif
      if (r < 3) feed(1, 7);
    end
    for (int c = 0; c < 5; c++) begin
      step(8'($urandom_range(0, 255)), 1'b0, 1'b0);
      n_vec++;
      if ({bus.phase_idx, bus.phase_vld, bus.wrap_pulse, bus.locked, bus.fault, bus.fault_code} !== 9'b000_0_0_1_0_00) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got %b want 000001000", c, {bus.phase_idx, bus.phase_vld, bus.wrap_pulse, bus.locked, bus.fault, bus.fault_code});
      end
`ifdef RING_MON_CNT_EN
      n_vec++;
      if (bus.rev_count !== 16'd3) begin n_bad++; $display("FAIL stall_rev[%0d]: got %0d want 3", c, bus.rev_count); end
`endif
    end
  endtask

  initial begin
    bus.ring_in   = '0;
    bus.ring_vld  = 1'b0;
    bus.fault_clr = 1'b0;
    test_reset();
    test_rotation();
    test_nohot();
    test_badrot();
    test_sync_drop();
    test_clr_same_cycle();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
